frame_buffer_sequencer: RTL

- Sequences a single-port frame memory holding one IMG_W x IMG_H greyscale frame.
- Phase FILL: accepts a raster pixel stream and writes it to memory.
- Phase DRAIN: reads the frame back in raster order and emits grey RGB pixels (R=G=B) with frame/line markers.
- Sits between the binary-image ingest stream and the RGB/PNG pixel consumer. It is the only master of the frame memory.

---
 rtl/frame_buffer_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_sequencer.sv
// Frame buffer sequencer: fills a single-port frame memory from a pixel stream, then drains it
// as grey RGB with frame/line markers. Optional binarising threshold under FBS_THRESH_EN.
module frame_buffer_sequencer #(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_pixel,
    output logic              in_ready,
`ifdef FBS_THRESH_EN
    input  logic [PIX_W-1:0]  thresh,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_r,
    output logic [PIX_W-1:0]  out_g,
    output logic [PIX_W-1:0]  out_b,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              busy,
    output logic              done
);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam int unsigned ENT_W = PIX_W + 3;

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

    state_e            state;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              rd_done;
    logic              inflight;
    logic [2:0]        inf_tags;
    logic [ENT_W-1:0]  slot0, slot1;
    logic [1:0]        count;

    logic              last_pos, wr_fire, rd_fire, pop;
    logic [2:0]        occ;
    logic [PIX_W-1:0]  push_pix;
    logic [ENT_W-1:0]  push_entry;

    always_comb begin
        last_pos  = (col == COL_LAST) && (row == ROW_LAST);
        out_valid = (count != 2'd0);
        pop       = out_valid && out_ready;
        wr_fire   = (state == StFill) && in_valid && !abort;
        // Entries already held or on their way, net of the pop this cycle.
        occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        rd_fire   = (state == StDrain) && !rd_done && !abort && (occ < 3'd2);
        in_ready  = (state == StFill) && !abort;
        mem_en    = wr_fire || rd_fire;
        mem_we    = wr_fire;
        mem_addr  = addr;
        mem_wdata = wr_fire ? in_pixel : '0;
        out_r     = slot0[PIX_W-1:0];
        out_g     = slot0[PIX_W-1:0];
        out_b     = slot0[PIX_W-1:0];
        out_sof   = out_valid && slot0[PIX_W];
        out_eol   = out_valid && slot0[PIX_W+1];
        out_eof   = out_valid && slot0[PIX_W+2];
        busy      = (state != StIdle);
        done      = (state == StDrain) && pop && slot0[PIX_W+2] && !abort;
`ifdef FBS_THRESH_EN
        push_pix  = (mem_rdata >= thresh) ? '1 : '0;
`else
        push_pix  = mem_rdata;
`endif
        push_entry = {inf_tags, push_pix};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            addr     <= '0;
            col      <= '0;
            row      <= '0;
            rd_done  <= 1'b0;
            inflight <= 1'b0;
            inf_tags <= '0;
            slot0    <= '0;
            slot1    <= '0;
            count    <= '0;
        end else if (abort) begin
            state    <= StIdle;
            addr     <= '0;
            col      <= '0;
            row      <= '0;
            rd_done  <= 1'b0;
            inflight <= 1'b0;
            inf_tags <= '0;
            slot0    <= '0;
            slot1    <= '0;
            count    <= '0;
        end else begin
            if (wr_fire || rd_fire) begin
                addr <= addr + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StFill;
                        addr  <= '0;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                StFill: begin
                    if (wr_fire && last_pos) begin
                        state   <= StDrain;
                        addr    <= '0;
                        col     <= '0;
                        row     <= '0;
                        rd_done <= 1'b0;
                    end
                end
                StDrain: begin
                    inflight <= rd_fire;
                    if (rd_fire) begin
                        inf_tags <= {last_pos, col == COL_LAST, addr == '0};
                        if (last_pos) rd_done <= 1'b1;
                    end
                    // Two-entry FIFO: slot0 is always the head.
                    case ({inflight, pop})
                        2'b10: begin
                            if (count == 2'd0) slot0 <= push_entry;
                            else               slot1 <= push_entry;
                            count <= count + 2'd1;
                        end
                        2'b01: begin
                            slot0 <= slot1;
                            count <= count - 2'd1;
                        end
                        2'b11: begin
                            if (count == 2'd1) begin
                                slot0 <= push_entry;
                            end else begin
                                slot0 <= slot1;
                                slot1 <= push_entry;
                            end
                        end
                        default: ;
                    endcase
                    if (done) begin
                        state   <= StIdle;
                        addr    <= '0;
                        col     <= '0;
                        row     <= '0;
                        rd_done <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
